dsd_output_formatter: RTL
=========================

# dsd_output_formatter

Output stage of the 1-bit delta-sigma modulator. Master of the DSD bit timing: it divides the master clock into the DSD bit rate and issues the bit strobe that advances the modulator loop. It samples the per-channel quantizer bits and drives DSD data and bit clock to the DAC. It inserts the DSD silence pattern at byte boundaries on mute, and detects modulator overload (stuck output) and forces mute.

## Interface
Reset is asynchronous, active-high.

Parameters:
- BCK_DIV, 4: MCLK cycles per DSD bit; must be even and ≥2.
- STUCK_LIMIT, 64: number of consecutive identical bits on one channel that declares overload; must be ≥2.
- MUTE_PATTERN, 8'h69: DSD silence byte, emitted MSB first.

Ports:
- MCLK_I  in  1  single clock; all logic on its rising edge.
- RST_I  in  1  asynchronous, active-high reset.
- QUANT_L_I, QUANT_R_I  in  1  quantizer bits from the modulator loop.
- MUTE_I  in  1  mute request, level-sensitive.
- FAULT_CLR_I  in  1  clears the sticky fault.
- BIT_EN_O  out  1  one-cycle bit strobe to the modulator loop.
- DSD_BCK_O  out  1  DSD bit clock.
- DSD_L_O, DSD_R_O  out  1  DSD data.
- MUTED_O  out  1  high while the silence pattern is being emitted.
- FAULT_O  out  1  sticky overload flag (OR of both channels).

## Operation
- Divider counter c runs 0..BCK_DIV-1 and wraps.
- BIT_EN_O = (c == BCK_DIV-1), decoded from the counter register. The edge ending that cycle is the "bit edge".
- Byte phase p is 0..7. It increments mod 8 on every bit edge.
- State machine has two states: MUTED and PLAY.
- On each bit edge:
  - In MUTED, both channels output MUTE_PATTERN[7-p].
  - In PLAY, DSD_L_O/DSD_R_O are loaded with QUANT_L_I/QUANT_R_I sampled at this edge.
- State change is evaluated only on bit edges with p==7. The new state takes effect from the next bit, which is phase 0.
  - PLAY→MUTED if MUTE_I or FAULT_O is high.
  - MUTED→PLAY if MUTE_I==0 and FAULT_O==0.
- MUTED_O is registered and follows the state; it changes on the same edge as the state.
- Stuck detection is per channel and active only in PLAY:
  - Run counter r, width clog2(STUCK_LIMIT+1), saturating.
  - On a bit edge: r ← r+1 if the bit equals the previous bit, else r ← 1.
  - r is forced to 0 in MUTED.
  - When r reaches STUCK_LIMIT, FAULT_O sets on that bit edge.
- FAULT_O is cleared only by RST_I or by FAULT_CLR_I sampled high on any MCLK edge. If a clear and a new detection occur on the same edge, detection wins.
- Fault forces mute at the next byte boundary. The stuck bits before that boundary are still emitted.

## Timing
- Reset values (immediate, asynchronous):
  - c=0, p=0, state=MUTED, r=0.
  - BIT_EN_O=0, DSD_BCK_O=0, DSD_L_O=0, DSD_R_O=0.
  - MUTED_O=1, FAULT_O=0.
- DSD_BCK_O is registered and glitch-free: 0 while c<BCK_DIV/2, 1 otherwise.
  - Data changes on the bit edge, which coincides with the BCK falling edge (c wraps to 0).
  - Data is stable a full bit period; the DAC samples on the BCK rising edge mid-period.
- Latency is one MCLK from the quantizer bit sampled at a bit edge to DSD_x_O.
- After reset, the first bit edge (MCLK edge BCK_DIV after reset release) emits pattern bit 7 (=0 for 0x69).
- MUTE_I/FAULT_O changes mid-byte are held off until the p==7 bit edge. Emitted bytes are never split between pattern and audio.
- Upstream contract: QUANT_x_I must be valid at each bit edge. The loop updates its state only on BIT_EN_O.
- If reset is asserted mid-byte, the phase restarts at 0 after release. There is no partial-byte recovery.

## Structure
- Shared package/include holds:
  - the state encoding (MUTED=0, PLAY=1);
  - the MUTE_PATTERN default 8'h69;
  - the clog2 function.
- One sub-module, dsd_stuck_detect, instantiated twice (L and R):
  - Inputs: clock, reset, bit strobe, play-enable, bit.
  - Output: stuck pulse.
  - Holds its previous-bit and run-counter registers.
- The top level holds the divider, BCK generation, phase counter, FSM, data registers and fault flag.

## Test plan
- Reset with MUTE_I=1, BCK_DIV=4:
  - BIT_EN_O pulses every 4th cycle.
  - DSD_BCK_O pattern is 0,0,1,1.
  - Both channels repeat 0,1,1,0,1,0,0,1.
  - MUTED_O=1, FAULT_O=0.
- MUTE_I falls after bit 3 of a pattern byte, QUANT_L_I=1 / QUANT_R_I=0 alternating:
  - Pattern bits 4–7 still emitted.
  - Quantizer bits appear from the next phase 0.
  - MUTED_O falls on the p==7 bit edge.
- MUTE_I rises at p=2 during PLAY:
  - Quantizer bits continue through p=7.
  - The next byte is exactly 0x69.
  - MUTED_O rises on the p==7 edge.
- STUCK_LIMIT=64, QUANT_L_I held at 1 in PLAY:
  - FAULT_O rises on the 64th bit edge; mute at the next byte boundary.
  - With MUTE_I=0 the block stays MUTED until a FAULT_CLR_I pulse, then returns to PLAY at the next byte boundary.
- FAULT_CLR_I asserted on the same edge as a new 64th identical bit: FAULT_O stays 1.
- 1000 alternating bits 1010… on both channels: FAULT_O stays 0.
- RST_I pulsed at p=5 mid-cycle:
  - All outputs go to their reset values before the next MCLK edge.
  - After release the pattern restarts at bit 7.

Source files
------------

// File: rtl/dsd_output_formatter_pkg.sv
// dsd_output_formatter_pkg: shared state encoding, silence byte and clog2 for the DSD output stage
package dsd_output_formatter_pkg;
  typedef enum logic {MUTED = 1'b0, PLAY = 1'b1} state_e;
  localparam logic [7:0] MUTE_PATTERN_DEF = 8'h69;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/dsd_stuck_detect.sv
// dsd_stuck_detect: per-channel run-length monitor that pulses when a bit repeats STUCK_LIMIT times in play
module dsd_stuck_detect
  import dsd_output_formatter_pkg::*;
#(
  parameter int STUCK_LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_en,
  input  logic play,
  input  logic bit_i,
  output logic stuck_o
);
  localparam int RW = clog2(STUCK_LIMIT + 1);
  localparam logic [RW-1:0] LIM = RW'(STUCK_LIMIT);
  logic [RW-1:0] run_q, run_d;
  logic prev_q, prev_d;
  // run restarts at 1 on a change; with run_q==0 the first play bit also lands on 1
  always_comb begin
    prev_d = bit_en && play ? bit_i : prev_q;
    run_d = !play ? '0 : !bit_en ? run_q : bit_i != prev_q ? RW'(1) : run_q == LIM ? LIM : run_q + 1'b1;
  end
  assign stuck_o = bit_en && play && run_q != LIM && run_d == LIM;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= '0;
      prev_q <= 1'b0;
    end else begin
      run_q <= run_d;
      prev_q <= prev_d;
    end
  end
endmodule

// File: rtl/dsd_output_formatter.sv
// dsd_output_formatter: DSD bit timing master, byte-aligned mute insertion and sticky overload fault
module dsd_output_formatter
  import dsd_output_formatter_pkg::*;
#(
  parameter int BCK_DIV = 4,
  parameter int STUCK_LIMIT = 64,
  parameter logic [7:0] MUTE_PATTERN = MUTE_PATTERN_DEF
) (
  input  logic MCLK_I,
  input  logic RST_I,
  input  logic QUANT_L_I,
  input  logic QUANT_R_I,
  input  logic MUTE_I,
  input  logic FAULT_CLR_I,
  output logic BIT_EN_O,
  output logic DSD_BCK_O,
  output logic DSD_L_O,
  output logic DSD_R_O,
  output logic MUTED_O,
  output logic FAULT_O
);
  localparam int CW = clog2(BCK_DIV);
  localparam logic [CW-1:0] C_LAST = CW'(BCK_DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(BCK_DIV / 2);
  logic [CW-1:0] c_q, c_d;
  logic [2:0] p_q, p_d;
  state_e state_q, state_d;
  logic bck_q, bck_d, l_q, l_d, r_q, r_d, muted_q, muted_d, fault_q, fault_d;
  logic bit_edge, play, stuck_l, stuck_r;
  assign bit_edge = c_q == C_LAST;
  assign play = state_q == PLAY;
  // BCK is computed from the next count so the registered clock lines up with c
  always_comb begin
    c_d = bit_edge ? '0 : c_q + 1'b1;
    bck_d = c_d >= C_HALF;
    p_d = bit_edge ? p_q + 3'd1 : p_q;
    state_d = bit_edge && p_q == 3'd7 ? (MUTE_I || fault_q ? MUTED : PLAY) : state_q;
    muted_d = state_d == MUTED;
    l_d = !bit_edge ? l_q : play ? QUANT_L_I : MUTE_PATTERN[~p_q];
    r_d = !bit_edge ? r_q : play ? QUANT_R_I : MUTE_PATTERN[~p_q];
    fault_d = stuck_l || stuck_r || (fault_q && !FAULT_CLR_I);
  end
  always_ff @(posedge MCLK_I or posedge RST_I) begin
    if (RST_I) begin
      c_q <= '0;
      p_q <= 3'd0;
      state_q <= MUTED;
      bck_q <= 1'b0;
      l_q <= 1'b0;
      r_q <= 1'b0;
      muted_q <= 1'b1;
      fault_q <= 1'b0;
    end else begin
      c_q <= c_d;
      p_q <= p_d;
      state_q <= state_d;
      bck_q <= bck_d;
      l_q <= l_d;
      r_q <= r_d;
      muted_q <= muted_d;
      fault_q <= fault_d;
    end
  end
  dsd_stuck_detect #(.STUCK_LIMIT(STUCK_LIMIT)) u_stuck_l (
    .clk(MCLK_I), .rst(RST_I), .bit_en(bit_edge), .play(play), .bit_i(QUANT_L_I), .stuck_o(stuck_l)
  );
  dsd_stuck_detect #(.STUCK_LIMIT(STUCK_LIMIT)) u_stuck_r (
    .clk(MCLK_I), .rst(RST_I), .bit_en(bit_edge), .play(play), .bit_i(QUANT_R_I), .stuck_o(stuck_r)
  );
  assign BIT_EN_O = bit_edge;
  assign DSD_BCK_O = bck_q;
  assign DSD_L_O = l_q;
  assign DSD_R_O = r_q;
  assign MUTED_O = muted_q;
  assign FAULT_O = fault_q;
endmodule
